// File: rtl/aquila_axi_pkg.sv
// Shared AXI response codes and the device-port FSM state encoding.
package aquila_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRESP,
    ST_RRESP
  } dev_port_state_e;

endpackage

// File: rtl/aquila_s_device_port.sv
// AXI4-Lite slave that replays one write or one read at a time on a single-beat
// device bus, with a watchdog that answers SLVERR if the device never responds.
module aquila_s_device_port
  import aquila_axi_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            DEV_strobe,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   DEV_addr,
  output logic                            DEV_rw,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] DEV_byte_enable,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   DEV_core2dev_data,
  input  logic                            DEV_data_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   DEV_dev2core_data
);

  localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dev_port_state_e state_q, state_d;

  logic              aw_full, w_full, ar_full;
  logic [AW-1:0]     awaddr_q, araddr_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              op_wr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              issue_wr_c, issue_rd_c, done_c;
  logic [1:0]        resp_c;
  logic [DW-1:0]     rdata_c;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic unused_prot;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Writes take priority over a pending read; device-ready beats the watchdog.
  always_comb begin
    state_d    = state_q;
    issue_wr_c = 1'b0;
    issue_rd_c = 1'b0;
    done_c     = 1'b0;
    resp_c     = AXI_RESP_OKAY;
    rdata_c    = '0;
    case (state_q)
      ST_IDLE: begin
        if (aw_full && w_full) begin
          issue_wr_c = 1'b1;
          state_d    = ST_ISSUE;
        end else if (ar_full) begin
          issue_rd_c = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (DEV_data_ready) begin
          done_c  = 1'b1;
          rdata_c = DEV_dev2core_data;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (DEV_data_ready) begin
          done_c  = 1'b1;
          rdata_c = DEV_dev2core_data;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          done_c = 1'b1;
          resp_c = AXI_RESP_SLVERR;
        end
      end
      ST_WRESP: if (S_AXI_BREADY) state_d = ST_IDLE;
      ST_RRESP: if (S_AXI_RREADY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (done_c) state_d = op_wr_q ? ST_WRESP : ST_RRESP;
  end

  // Channel capture; READY is the registered complement of each full flag.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      if (aw_hs) begin
        awaddr_q      <= S_AXI_AWADDR;
        aw_full       <= 1'b1;
        S_AXI_AWREADY <= 1'b0;
      end else if (b_hs) begin
        aw_full       <= 1'b0;
        S_AXI_AWREADY <= 1'b1;
      end else begin
        S_AXI_AWREADY <= !aw_full;
      end

      if (w_hs) begin
        wdata_q      <= S_AXI_WDATA;
        wstrb_q      <= S_AXI_WSTRB;
        w_full       <= 1'b1;
        S_AXI_WREADY <= 1'b0;
      end else if (b_hs) begin
        w_full       <= 1'b0;
        S_AXI_WREADY <= 1'b1;
      end else begin
        S_AXI_WREADY <= !w_full;
      end

      if (ar_hs) begin
        araddr_q      <= S_AXI_ARADDR;
        ar_full       <= 1'b1;
        S_AXI_ARREADY <= 1'b0;
      end else if (r_hs) begin
        ar_full       <= 1'b0;
        S_AXI_ARREADY <= 1'b1;
      end else begin
        S_AXI_ARREADY <= !ar_full;
      end
    end
  end

  // Device request, watchdog and AXI response registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      DEV_strobe        <= 1'b0;
      DEV_addr          <= '0;
      DEV_rw            <= 1'b0;
      DEV_byte_enable   <= '0;
      DEV_core2dev_data <= '0;
      op_wr_q           <= 1'b0;
      cnt_q             <= '0;
      S_AXI_BVALID      <= 1'b0;
      S_AXI_BRESP       <= '0;
      S_AXI_RVALID      <= 1'b0;
      S_AXI_RRESP       <= '0;
      S_AXI_RDATA       <= '0;
    end else begin
      DEV_strobe <= issue_wr_c || issue_rd_c;
      if (issue_wr_c) begin
        DEV_addr          <= awaddr_q;
        DEV_rw            <= 1'b1;
        DEV_byte_enable   <= wstrb_q;
        DEV_core2dev_data <= wdata_q;
        op_wr_q           <= 1'b1;
      end else if (issue_rd_c) begin
        DEV_addr          <= araddr_q;
        DEV_rw            <= 1'b0;
        DEV_byte_enable   <= '1;
        DEV_core2dev_data <= '0;
        op_wr_q           <= 1'b0;
      end

      if ((state_q == ST_WAIT) && !done_c) cnt_q <= cnt_q + CNT_W'(1);
      else                                 cnt_q <= '0;

      if (done_c) begin
        if (op_wr_q) begin
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= resp_c;
        end else begin
          S_AXI_RVALID <= 1'b1;
          S_AXI_RRESP  <= resp_c;
          S_AXI_RDATA  <= rdata_c;
        end
      end
      if (b_hs) S_AXI_BVALID <= 1'b0;
      if (r_hs) S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: doc/aquila_s_device_port.md
Name: aquila_s_device_port

Overview:
- AXI4-Lite slave port that terminates AXI-Lite transactions from an interconnect and replays them on a simple single-beat device interface (strobe/rw/addr/byte_enable/data, ready/data).
- It is the responder-side counterpart of the core's uncached device master port, and is used to attach local peripherals or register banks behind an AXI-Lite crossbar.
- Supports one outstanding write and one outstanding read.
- Has a watchdog that returns SLVERR when the device never answers.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, AXI and device address width.
- C_S_AXI_DATA_WIDTH, 32, AXI and device data width (byte_enable width is DATA_WIDTH/8).
- TIMEOUT_CYCLES, 256, device-wait watchdog limit in cycles. 0 disables the watchdog.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  ADDR  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  DATA  write data
- S_AXI_WSTRB  in  DATA/8  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  master accepts response
- S_AXI_ARADDR  in  ADDR  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  DATA  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  master accepts read data
- DEV_strobe  out  1  one-cycle request pulse to device
- DEV_addr  out  ADDR  request address
- DEV_rw  out  1  1 = write, 0 = read
- DEV_byte_enable  out  DATA/8  write byte enables
- DEV_core2dev_data  out  DATA  write data
- DEV_data_ready  in  1  device completion pulse
- DEV_dev2core_data  in  DATA  read data, valid with DEV_data_ready

Behaviour:
- Reset (S_AXI_ARESETN=0 at a clock edge):
  - All registered outputs go to 0. The aw_full, w_full and ar_full flags go to 0. FSM goes to IDLE. Watchdog counter goes to 0.
  - A transaction in flight mid-operation is discarded with no response. DEV_data_ready is ignored during reset.
- Capture registers:
  - AWREADY = !aw_full; WREADY = !w_full; ARREADY = !ar_full. Each is driven from registers only, with no combinational path from any VALID.
  - On VALID&&READY the payload is latched and the matching full flag is set on the next edge.
  - AW and W are accepted independently, in either order.
  - aw_full and w_full clear on the B handshake. ar_full clears on the R handshake.
- FSM states: IDLE, ISSUE, WAIT, WRESP, RRESP.
  - IDLE: if aw_full&&w_full, go to ISSUE as a write. Else if ar_full, go to ISSUE as a read. When both are eligible in the same cycle, the write wins. A read already captured is served after that write completes.
  - ISSUE (exactly one cycle): DEV_strobe=1. DEV_rw, DEV_addr, DEV_byte_enable and DEV_core2dev_data are driven from the latched payload. For reads DEV_byte_enable=all ones and DEV_core2dev_data=0. Next state is WAIT, unless DEV_data_ready=1 in this cycle, which completes immediately.
  - WAIT: DEV_addr, DEV_rw and data are held stable and DEV_strobe=0. The counter increments each cycle.
    - DEV_data_ready=1: completion with resp=OKAY (2'b00). Reads latch DEV_dev2core_data into RDATA.
    - Counter reaches TIMEOUT_CYCLES-1 without ready (and TIMEOUT_CYCLES≠0): completion with resp=SLVERR (2'b10) and RDATA=0.
    - If ready and timeout occur in the same cycle, ready wins (OKAY).
  - Completion: go to WRESP (BVALID=1, BRESP=resp) or RRESP (RVALID=1, RRESP=resp, RDATA). The counter clears.
  - WRESP/RRESP: BRESP/RRESP and RDATA are held stable while VALID is high. On BREADY (resp. RREADY), VALID drops on the next edge, the matching full flags clear, and the FSM returns to IDLE.
- DEV_data_ready arriving in IDLE, WRESP or RRESP is ignored.
- Minimum latency: AW+W handshake at cycle 0, ISSUE at cycle 2, device ready at cycle 2, BVALID at cycle 3.
- A new AW/W may be accepted while a read is in progress, and a new AR while a write is in progress. Each is held until the FSM returns to IDLE.
- WSTRB=0 is still forwarded to the device as a write.

Decomposition:
- Shared package aquila_axi_pkg:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
  - FSM state enum for this block.
- No sub-module is required; everything is flat in one module.
- The watchdog counter width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Write, AW and W together: AWADDR=0x10, WDATA=0xCAFE0001, WSTRB=4'b0011; device asserts ready 3 cycles after the strobe.
   -> DEV_strobe is high for exactly 1 cycle with addr=0x10, be=0011; then BVALID with BRESP=00.
2. Write with W arriving 5 cycles before AW.
   -> No DEV_strobe until both are captured; then a single strobe; AWREADY and WREADY stay low until the B handshake.
3. Read at ARADDR=0x24; device returns 0x12345678 together with ready in the ISSUE cycle.
   -> RVALID on the next cycle with RDATA=0x12345678, RRESP=00; RDATA is held while RREADY is low for 4 cycles.
4. Read with TIMEOUT_CYCLES=8 and the device never ready.
   -> RVALID 8 cycles after WAIT entry with RRESP=10, RDATA=0; a subsequent read with ready returns OKAY.
5. AR, AW and W all captured in the same cycle.
   -> Write strobe first, then the read strobe only after the B handshake; both responses are OKAY.
6. Reset asserted in WAIT.
   -> Next cycle all VALID/READY outputs and DEV_strobe are 0 and the FSM is in IDLE; a late DEV_data_ready is ignored; the next transaction completes normally.
